semaforo_monitor: RTL

Passive checker on the traffic-light output interface (green/yellow/red). It decodes the light phase every clock and enforces the GO->WAIT->STOP->GO order and one-hot encoding. It measures how long each phase is held and flags dwell-time violations against per-phase min/max limits. It sits beside the light controller, clocked by the same divided clock, and drives sticky error flags plus measurement outputs for debug/LEDs.

---
 rtl/semaforo_monitor.sv | 120 ++++++++++++
 1 files changed

// File: rtl/semaforo_monitor.sv
// semaforo_monitor: passive checker for green/yellow/red phase order, one-hot coding and dwell limits.
// Define SEMAFORO_MON_ROUNDS_EN to build the completed-round counter; otherwise round_cnt is tied to 0.
module semaforo_monitor #(
  parameter int CNT_W = 16,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_MIN = 2,
  parameter int YELLOW_MAX = 4,
  parameter int RED_MIN = 4,
  parameter int RED_MAX = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             green,
  input  logic             yellow,
  input  logic             red,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic             dwell_valid,
  output logic             err_onehot,
  output logic             err_order,
  output logic             err_time,
  output logic [7:0]       round_cnt
);
  typedef enum logic [1:0] {GO = 2'b00, WAIT = 2'b01, STOP = 2'b10, SYNC = 2'b11} state_t;
  state_t state, state_n, code, succ;
  logic [CNT_W-1:0] timer, timer_n, dwell_n, min_lim, max_lim;
  logic partial, partial_n, dv_n, legal, set_onehot, set_order, set_time;
  // SYNC doubles as the "invalid code" marker for the decoded light pattern
  always_comb begin
    code = {green, yellow, red} == 3'b100 ? GO :
           {green, yellow, red} == 3'b010 ? WAIT :
           {green, yellow, red} == 3'b001 ? STOP : SYNC;
    succ = state == GO ? WAIT : state == WAIT ? STOP : GO;
    min_lim = state == GO ? CNT_W'(GREEN_MIN) : state == WAIT ? CNT_W'(YELLOW_MIN) : CNT_W'(RED_MIN);
    max_lim = state == GO ? CNT_W'(GREEN_MAX) : state == WAIT ? CNT_W'(YELLOW_MAX) : CNT_W'(RED_MAX);
  end
  always_comb begin
    state_n = state;
    timer_n = timer;
    partial_n = partial;
    dwell_n = dwell;
    dv_n = 1'b0;
    legal = 1'b0;
    set_onehot = 1'b0;
    set_order = 1'b0;
    set_time = 1'b0;
    if (state == SYNC) begin
      if (code == GO) begin
        state_n = GO;
        timer_n = CNT_W'(1);
        partial_n = 1'b1;
      end
    end else if (code == SYNC) begin
      set_onehot = 1'b1;
      state_n = SYNC;
      timer_n = '0;
    end else if (code == state) begin
      timer_n = timer == '1 ? timer : timer + CNT_W'(1);
      // firing only on the MAX -> MAX+1 step makes the overrun flag one-shot per phase
      set_time = timer == max_lim && timer != '1;
    end else begin
      legal = code == succ;
      set_order = !legal;
      set_time = legal && !partial && timer < min_lim;
      dwell_n = partial ? dwell : timer;
      dv_n = !partial;
      state_n = code;
      timer_n = CNT_W'(1);
      partial_n = 1'b0;
    end
  end
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      state <= SYNC;
      timer <= '0;
      partial <= 1'b0;
      dwell <= '0;
      dwell_valid <= 1'b0;
      err_onehot <= 1'b0;
      err_order <= 1'b0;
      err_time <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      partial <= partial_n;
      dwell <= dwell_n;
      dwell_valid <= dv_n;
      err_onehot <= set_onehot | (err_onehot & ~clr_err);
      err_order <= set_order | (err_order & ~clr_err);
      err_time <= set_time | (err_time & ~clr_err);
    end
  assign phase = state;
`ifdef SEMAFORO_MON_ROUNDS_EN
  // stage: 0 idle, 1 clean GO, 2 clean WAIT, 3 clean STOP
  logic [1:0] stage, stage_n;
  logic [7:0] round_n;
  always_comb begin
    stage_n = stage;
    round_n = round_cnt;
    if (set_onehot | set_order | set_time)
      stage_n = 2'd0;
    else if (legal) begin
      stage_n = state == STOP ? 2'd1 : stage != 2'd0 ? stage + 2'd1 : 2'd0;
      round_n = state == STOP && stage == 2'd3 ? round_cnt + 8'd1 : round_cnt;
    end
  end
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      stage <= 2'd0;
      round_cnt <= 8'd0;
    end else begin
      stage <= stage_n;
      round_cnt <= round_n;
    end
`else
  assign round_cnt = 8'd0;
`endif
endmodule
